// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the CPU/DMA memory port arbiter: FSM states, owner
// identifiers and the default memory latency.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam int DEFAULT_MEM_LATENCY = 2;

    // Access counter width; bounds MEM_LATENCY to 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// whichever requester did not own the port last.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant = ~last_owner;
        end else if (req1) begin
            grant = OWNER_DMA;
        end else begin
            grant = OWNER_CPU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the CPU control path and the
// DMA/program loader: latch the winner, run the memory, pulse ready once.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              grant_dma
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              last_owner_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    logic              mem_en_q;
    logic              mem_we_q;
    logic              busy_q;
    logic              grant_dma_q;
    logic              cpu_ready_q;
    logic              dma_ready_q;

    logic              pick_grant;
    logic              pick_valid;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    rr_arbiter2 u_rr_arbiter2 (
        .req0        (cpu_req),
        .req1        (dma_req),
        .last_owner  (last_owner_q),
        .grant       (pick_grant),
        .grant_valid (pick_valid)
    );

    // Request fields of whichever requester the arbiter is picking this cycle.
    assign sel_we_d    = (pick_grant == OWNER_DMA) ? dma_we    : cpu_we;
    assign sel_addr_d  = (pick_grant == OWNER_DMA) ? dma_addr  : cpu_addr;
    assign sel_wdata_d = (pick_grant == OWNER_DMA) ? dma_wdata : cpu_wdata;

    assign cnt_d   = cnt_q - CNT_LAST;
    // Writes keep the previous read data in the rdata register.
    assign rdata_d = we_q ? rdata_q : mem_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            cnt_q        <= '0;
            last_owner_q <= OWNER_DMA;
            owner_q      <= OWNER_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            grant_dma_q  <= 1'b0;
            cpu_ready_q  <= 1'b0;
            dma_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner_q     <= pick_grant;
                        we_q        <= sel_we_d;
                        addr_q      <= sel_addr_d;
                        wdata_q     <= sel_wdata_d;
                        cnt_q       <= CNT_LOAD;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we_d;
                        busy_q      <= 1'b1;
                        grant_dma_q <= pick_grant;
                        state_q     <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    // The strobe lives only in the first ACCESS cycle.
                    cnt_q    <= cnt_d;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        rdata_q     <= rdata_d;
                        cpu_ready_q <= (owner_q == OWNER_CPU);
                        dma_ready_q <= (owner_q == OWNER_DMA);
                        state_q     <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    cpu_ready_q  <= 1'b0;
                    dma_ready_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    last_owner_q <= owner_q;
                    grant_dma_q  <= owner_q;
                    state_q      <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign grant_dma = grant_dma_q;
    assign cpu_ready = cpu_ready_q;
    assign dma_ready = dma_ready_q;
    assign cpu_rdata = cpu_ready_q ? rdata_q : '0;
    assign dma_rdata = dma_ready_q ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner
// sequences, a MEM_LATENCY=1 instance and a randomized transaction-level model.
module tb_mem_port_arbiter;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A (MEM_LATENCY = 2)
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
    logic        cpu_ready, dma_ready, mem_en, mem_we, busy, grant_dma;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

    // Instance B (MEM_LATENCY = 1)
    logic        b_cpu_req = 0, b_cpu_we = 0, b_dma_req = 0, b_dma_we = 0;
    logic [31:0] b_cpu_addr = 0, b_cpu_wdata = 0, b_dma_addr = 0, b_dma_wdata = 0;
    logic        b_cpu_ready, b_dma_ready, b_mem_en, b_mem_we, b_busy, b_grant_dma;
    logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_dma(grant_dma)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ready(b_cpu_ready), .cpu_rdata(b_cpu_rdata),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
        .dma_ready(b_dma_ready), .dma_rdata(b_dma_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy), .grant_dma(b_grant_dma)
    );

    // Memory device for A: data is valid only in the cycle LAT_A-1 after mem_en,
    // every other cycle returns a junk pattern.
    logic [31:0] dev_mem [0:255] = '{default: 32'h0};
    logic [7:0]  dev_addr_q = 8'h0;
    int          dev_age_q = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            dev_addr_q <= mem_addr[7:0];
            dev_age_q  <= 0;
            if (mem_we) dev_mem[mem_addr[7:0]] <= mem_wdata;
        end else begin
            dev_age_q <= dev_age_q + 1;
        end
    end

    always_comb begin
        int       phase;
        logic [7:0] ra;
        phase = mem_en ? 0 : dev_age_q + 1;
        ra    = mem_en ? mem_addr[7:0] : dev_addr_q;
        mem_rdata = (phase == LAT_A - 1) ? dev_mem[ra] : (32'hBAD0_0000 | 32'(phase));
    end

    assign b_mem_rdata = b_mem_en ? (b_mem_we ? 32'h0BAD_0BAD : 32'hCAFE_F00D) : 32'h0;

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cpu_req = 0; dma_req = 0; b_cpu_req = 0; b_dma_req = 0;
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_grant_dma", grant_dma, 1'b0);
        chk1("rst_cpu_ready", cpu_ready, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_req(input bit dma, input bit req, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (dma) begin
            dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    typedef struct {
        bit          dma;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          drop;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    // Single isolated transaction on A; ready expected exactly LAT_A+1 cycles after the request.
    task automatic run_vec(input vec_t v, input int idx);
        bit own_rdy;
        @(negedge clk);
        set_req(v.dma, 1'b1, v.we, v.addr, v.wdata);
        for (int k = 1; k <= LAT_A + 3; k++) begin
            @(negedge clk);
            own_rdy = (k == LAT_A + 1);
            chk1($sformatf("v%0d_mem_en_k%0d", idx, k), mem_en, k == 1);
            chk1($sformatf("v%0d_busy_k%0d", idx, k), busy, k <= LAT_A + 1);
            chk1($sformatf("v%0d_grant_dma_k%0d", idx, k), grant_dma, v.dma);
            if (k <= LAT_A) chk32($sformatf("v%0d_mem_addr_k%0d", idx, k), mem_addr, v.addr);
            if (k == 1) chk1($sformatf("v%0d_mem_we", idx), mem_we, v.we);
            if (k == 1 && v.we) chk32($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
            chk1($sformatf("v%0d_cpu_ready_k%0d", idx, k), cpu_ready, own_rdy && !v.dma);
            chk1($sformatf("v%0d_dma_ready_k%0d", idx, k), dma_ready, own_rdy && v.dma);
            chk32($sformatf("v%0d_cpu_rdata_k%0d", idx, k), cpu_rdata,
                  (own_rdy && !v.dma) ? v.exp_rdata : 32'h0);
            chk32($sformatf("v%0d_dma_rdata_k%0d", idx, k), dma_rdata,
                  (own_rdy && v.dma) ? v.exp_rdata : 32'h0);
            if (own_rdy || (k == 1 && v.drop)) set_req(v.dma, 1'b0, v.we, v.addr, v.wdata);
        end
        $display("vec %0d: %s %s addr=0x%02h drop=%0d done", idx, v.dma ? "DMA" : "CPU",
                 v.we ? "write" : "read", v.addr, v.drop);
    endtask

    // Random-phase reference model state (transaction level, cycle arithmetic).
    logic [31:0] ref_mem [0:255];
    bit          pend [2];
    bit          granted [2];
    bit          er [2];
    int          rdy_cyc [2];
    logic [31:0] exp_d [2];
    bit          r_we [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];

    initial begin
        int          free_at, men_cyc, w;
        bit          last_dma, men_we, men_owner;
        logic [31:0] last_read, men_addr, men_wdata;

        vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b0, 32'h40, 32'h0,        1'b1, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b1, 32'h20, 32'hA5A55A5A, 1'b1, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'hA5A55A5A};
        vecs[7] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 32'h0};

        do_reset();
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Both requesters held high: CPU first after reset, then strict alternation.
        do_reset();
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            bit dma_turn;
            @(negedge clk);
            dma_turn = ((k / 4) % 2) == 1;
            chk1($sformatf("alt_mem_en_k%0d", k), mem_en, (k % 4) == 1);
            if ((k % 4) == 1) chk1($sformatf("alt_grant_dma_k%0d", k), grant_dma, dma_turn);
            chk1($sformatf("alt_cpu_ready_k%0d", k), cpu_ready, (k % 4) == 3 && !dma_turn);
            chk1($sformatf("alt_dma_ready_k%0d", k), dma_ready, (k % 4) == 3 && dma_turn);
            if ((k % 4) == 3)
                chk32($sformatf("alt_rdata_k%0d", k), dma_turn ? dma_rdata : cpu_rdata,
                      dma_turn ? 32'h12345678 : 32'hDEADBEEF);
        end
        cpu_req = 0; dma_req = 0;
        $display("alternation sequence done");
        repeat (2) begin
            @(negedge clk);
            chk1("alt_tail_mem_en", mem_en, 1'b0);
        end

        // Reset in the middle of an access, then a tie must go to the CPU.
        do_reset();
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        chk1("midrst_pre_mem_en", mem_en, 1'b1);
        #2;
        reset_n = 1'b0;
        set_req(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk1("midrst_mem_en", mem_en, 1'b0);
        chk1("midrst_mem_we", mem_we, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_grant_dma", grant_dma, 1'b0);
        chk32("midrst_mem_addr", mem_addr, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk1("midrst_cpu_ready", cpu_ready, 1'b0);
            chk1("midrst_dma_ready", dma_ready, 1'b0);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= LAT_A + 1; k++) begin
            @(negedge clk);
            chk1($sformatf("postrst_mem_en_k%0d", k), mem_en, k == 1);
            if (k == 1) chk1("postrst_grant_dma", grant_dma, 1'b0);
            chk1($sformatf("postrst_cpu_ready_k%0d", k), cpu_ready, k == LAT_A + 1);
            chk1($sformatf("postrst_dma_ready_k%0d", k), dma_ready, 1'b0);
            if (k == LAT_A + 1) chk32("postrst_cpu_rdata", cpu_rdata, 32'h12345678);
        end
        cpu_req = 0; dma_req = 0;
        $display("mid-access reset sequence done");

        // MEM_LATENCY = 1 instance: strobe and capture share one ACCESS cycle.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            if (t == 0) begin
                b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h8;
            end else begin
                b_dma_req = 1; b_dma_we = 1; b_dma_addr = 32'h8; b_dma_wdata = 32'h1;
            end
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                chk1($sformatf("l1_t%0d_mem_en_k%0d", t, k), b_mem_en, k == 1);
                if (k == 1) chk32($sformatf("l1_t%0d_mem_addr", t), b_mem_addr, 32'h8);
                chk1($sformatf("l1_t%0d_cpu_ready_k%0d", t, k), b_cpu_ready, k == 2 && t == 0);
                chk1($sformatf("l1_t%0d_dma_ready_k%0d", t, k), b_dma_ready, k == 2 && t == 1);
                chk32($sformatf("l1_t%0d_rdata_k%0d", t, k), t == 0 ? b_cpu_rdata : b_dma_rdata,
                      k == 2 ? 32'hCAFEF00D : 32'h0);
                if (k == 2) begin b_cpu_req = 0; b_dma_req = 0; end
            end
            $display("latency-1 transaction %0d done", t);
        end

        // Randomized traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = dev_mem[i];
        free_at = 0; last_dma = 1'b1; last_read = 32'h0;
        men_cyc = -100; men_we = 0; men_owner = 0; men_addr = 0; men_wdata = 0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 0; granted[r] = 0; rdy_cyc[r] = -100; exp_d[r] = 0;
            r_we[r] = 0; r_addr[r] = 0; r_wdata[r] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) er[r] = granted[r] && (rdy_cyc[r] == cyc);
            chk1("rnd_cpu_ready", cpu_ready, er[0]);
            chk1("rnd_dma_ready", dma_ready, er[1]);
            chk32("rnd_cpu_rdata", cpu_rdata, er[0] ? exp_d[0] : 32'h0);
            chk32("rnd_dma_rdata", dma_rdata, er[1] ? exp_d[1] : 32'h0);
            chk1("rnd_mem_en", mem_en, cyc == men_cyc);
            chk1("rnd_busy", busy, cyc >= men_cyc && cyc <= men_cyc + LAT_A);
            if (cyc >= men_cyc && cyc <= men_cyc + LAT_A)
                chk1("rnd_grant_dma", grant_dma, men_owner);
            if (cyc == men_cyc) begin
                chk32("rnd_mem_addr", mem_addr, men_addr);
                chk1("rnd_mem_we", mem_we, men_we);
                if (men_we) chk32("rnd_mem_wdata", mem_wdata, men_wdata);
            end
            if (er[0] || er[1])
                $display("rnd cyc %0d: %s ready rdata=0x%08h", cyc, er[1] ? "DMA" : "CPU",
                         er[1] ? dma_rdata : cpu_rdata);

            for (int r = 0; r < 2; r++) begin
                if (er[r]) begin granted[r] = 0; pend[r] = 0; end
                if (granted[r] && pend[r] && $urandom_range(0, 3) == 0) begin
                    pend[r] = 0;
                end else if (!granted[r] && !pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r]    = 1;
                    r_we[r]    = $urandom_range(0, 1) == 1;
                    r_addr[r]  = 32'($urandom_range(0, 31));
                    r_wdata[r] = $urandom;
                end
                set_req(r == 1, pend[r], r_we[r], r_addr[r], r_wdata[r]);
            end

            if (cyc >= free_at && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? (last_dma ? 0 : 1) : (pend[1] ? 1 : 0);
                granted[w] = 1;
                rdy_cyc[w] = cyc + LAT_A + 1;
                free_at    = cyc + LAT_A + 2;
                men_cyc    = cyc + 1;
                men_owner  = (w == 1);
                men_we     = r_we[w];
                men_addr   = r_addr[w];
                men_wdata  = r_wdata[w];
                if (r_we[w]) begin
                    ref_mem[r_addr[w][7:0]] = r_wdata[w];
                    exp_d[w] = last_read;
                end else begin
                    exp_d[w] = ref_mem[r_addr[w][7:0]];
                end
                last_read = exp_d[w];
                last_dma  = (w == 1);
            end
        end
        cpu_req = 0; dma_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the multicycle CPU control path and the DMA/program loader.
- Sequences each access against a fixed-latency memory: latches the request, drives the memory for MEM_LATENCY cycles, then returns a one-cycle ready/rdata to the winner.
- The CPU FSM holds its current state while cpu_req is high and cpu_ready is low.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, memory cycles from mem_en to valid mem_rdata plus one. Legal range is 1 to 15.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ready  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready is high.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ready, dma_rdata: same meanings, for the DMA requester.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in ACCESS and RESP.
- grant_dma  out  1  current or last owner: 1 = DMA, 0 = CPU.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = IDLE, cnt = 0, last_owner = DMA (so the CPU wins the first tie).
  - All outputs 0. rdata register = 0.
  - Reset mid-access discards the transaction; no ready pulse is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester that is not last_owner (round-robin).
  - On the grant edge: latch owner, we, addr, wdata; cnt <= MEM_LATENCY; state <= ACCESS.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers and are stable for every ACCESS cycle.
  - mem_en = 1 only in the first ACCESS cycle (cnt == MEM_LATENCY).
  - mem_we = latched we AND mem_en.
  - cnt decrements each cycle.
  - mem_rdata is valid in the ACCESS cycle where cnt == 1. On that edge: capture mem_rdata (reads only; writes leave the rdata register unchanged), state <= RESP.
- RESP:
  - Owner's ready = 1 for exactly one cycle; its rdata output is driven from the rdata register.
  - The other requester's ready stays 0.
  - last_owner <= owner; state <= IDLE.
- Latency: req sampled in IDLE at cycle t gives ready at t + MEM_LATENCY + 1. The minimum back-to-back period is MEM_LATENCY + 2 cycles.
- Requester rules:
  - Hold req, we, addr, wdata stable until ready is seen.
  - req is ignored outside IDLE.
  - Dropping req mid-access does not abort: the access completes and ready still pulses.
  - A req still high in the IDLE cycle after RESP counts as a new request.
- The losing requester waits with no timeout. Round-robin bounds its wait to one access.
- cpu_rdata and dma_rdata are 0 whenever their ready is 0.
- grant_dma reflects the latched owner in ACCESS and RESP, and last_owner in IDLE.
- cnt width is 4 bits.

Decomposition:
- Shared package / include holds:
  - ARB_IDLE, ARB_ACCESS, ARB_RESP state encodings (2-bit).
  - OWNER_CPU = 0, OWNER_DMA = 1.
  - Default MEM_LATENCY.
- One sub-module is natural: rr_arbiter2.
  - Combinational two-way round-robin pick from req0, req1, last_owner.
  - Output: grant and grant_valid.
- The counter and FSM stay in the top module.

Test Plan:
- Reset, then CPU read of addr 0x10 with MEM_LATENCY = 2 and memory returning 0xDEADBEEF: mem_en exactly at t+1 with mem_addr = 0x10 through t+2; cpu_ready and cpu_rdata = 0xDEADBEEF at t+3; dma_ready stays 0.
- DMA write of addr 0x40, data 0x12345678: a single mem_en/mem_we pulse with mem_addr = 0x40 and mem_wdata = 0x12345678; dma_ready at t+3; a later CPU read of 0x40 returns 0x12345678.
- cpu_req and dma_req both held high continuously: grants alternate CPU, DMA, CPU, DMA; ready pulses every 4 cycles; grant_dma toggles 0,1,0,1.
- cpu_req dropped in the first ACCESS cycle: the access completes and cpu_ready still pulses at t+3; no new grant follows.
- reset_n pulsed low during ACCESS: all outputs go to 0 immediately; no ready pulse; after release, a DMA/CPU tie goes to the CPU.
- MEM_LATENCY = 1: mem_en and rdata capture happen in the same ACCESS cycle; ready at t+2.
